redux_mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port Redux data memory (256 x 8) between the core's load/store path (cpu port) and a debug/loader port (dbg port) used for preloading and dumping memory without stopping the core. Sits between the core, the debug agent and the data memory; the memory has 1-cycle synchronous read. Arbitration is fixed-priority with starvation protection, plus an optional debug burst lock.

---
 rtl/redux_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_redux_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/redux_mem_arbiter.sv
// Two-port arbiter for the Redux 256x8 data memory: cpu vs debug, fixed priority with
// starvation protection and debug burst lock. Define REDUX_ARB_RR_EN for round-robin tie-break.
module redux_mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DBG} owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_t     r_state, w_state_nxt;
  logic [3:0] r_cpu_wait, r_dbg_wait;
  logic [3:0] w_cpu_wait_nxt, w_dbg_wait_nxt;
  logic       r_cpu_rvalid, r_dbg_rvalid;
  logic       w_cpu_req, w_dbg_req, w_pick_dbg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cpu_wait   <= '0;
      r_dbg_wait   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_wait   <= w_cpu_wait_nxt;
      r_dbg_wait   <= w_dbg_wait_nxt;
      r_cpu_rvalid <= cpu_gnt & ~cpu_we;
      r_dbg_rvalid <= dbg_gnt & ~dbg_we;
    end
  end

  always_comb begin
    // Requests are masked by reset so grants and memory strobes are 0 while reset is low.
    w_cpu_req      = cpu_req & reset;
    w_dbg_req      = dbg_req & reset;
    w_pick_dbg     = 1'b0;
    w_state_nxt    = IDLE;
    w_cpu_wait_nxt = '0;
    w_dbg_wait_nxt = '0;
    cpu_gnt        = 1'b0;
    dbg_gnt        = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    if (w_cpu_req && w_dbg_req) begin
      if (r_dbg_wait == WAIT_MAX)
        w_pick_dbg = 1'b1;
      else if (r_cpu_wait == WAIT_MAX)
        w_pick_dbg = 1'b0;
      else if (r_state == OWN_DBG && dbg_lock)
        w_pick_dbg = 1'b1;
      else begin
`ifdef REDUX_ARB_RR_EN
        w_pick_dbg = (r_state == OWN_CPU);
`else
        w_pick_dbg = 1'b0;
`endif
      end
    end else begin
      w_pick_dbg = w_dbg_req;
    end

    cpu_gnt = w_cpu_req & ~w_pick_dbg;
    dbg_gnt = w_dbg_req & w_pick_dbg;

    if (dbg_gnt) begin
      w_state_nxt = OWN_DBG;
      mem_en      = 1'b1;
      mem_we      = dbg_we;
      mem_addr    = dbg_addr;
      mem_wdata   = dbg_wdata;
    end else if (cpu_gnt) begin
      // A starvation slot taken by cpu does not break an active debug lock.
      w_state_nxt = (r_state == OWN_DBG && dbg_lock && w_dbg_req) ? OWN_DBG : OWN_CPU;
      mem_en      = 1'b1;
      mem_we      = cpu_we;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
    end

    if (w_cpu_req && !cpu_gnt)
      w_cpu_wait_nxt = (r_cpu_wait < WAIT_MAX) ? r_cpu_wait + 4'd1 : r_cpu_wait;
    if (w_dbg_req && !dbg_gnt)
      w_dbg_wait_nxt = (r_dbg_wait < WAIT_MAX) ? r_dbg_wait + 4'd1 : r_dbg_wait;
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = r_dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_redux_mem_arbiter.sv
// Scoreboard bench for redux_mem_arbiter: stimulus pushes expected grants/read data,
// a negedge monitor pops and compares. Expectations follow REDUX_ARB_RR_EN when defined.
module tb_redux_mem_arbiter;

  logic       clk, reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  redux_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic       dbg;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } gnt_t;

  gnt_t       exp_gnt[$];
  logic [7:0] exp_cpu_rd[$];
  logic [7:0] exp_dbg_rd[$];
  gnt_t       mon_e, mon_got;
  logic [7:0] mon_rd;
  logic [7:0] tb_mem [256];
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory model, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (cpu_gnt || dbg_gnt) begin
      checks++;
      mon_got = {dbg_gnt, mem_we, mem_addr, mem_wdata};
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt t=%0t: got cpu_gnt=%0b dbg_gnt=%0b, required no grant",
                 $time, cpu_gnt, dbg_gnt);
      end else begin
        mon_e = exp_gnt.pop_front();
        if (cpu_gnt == dbg_gnt || !mem_en || mon_got != mon_e) begin
          errors++;
          $display("FAIL grant t=%0t: got gnt c/d=%0b/%0b en=%0b {dbg,we,addr,wdata}=%h, required %h",
                   $time, cpu_gnt, dbg_gnt, mem_en, mon_got, mon_e);
        end
      end
    end
    if (cpu_rvalid) begin
      checks++;
      if (exp_cpu_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cpu_rvalid t=%0t: got rdata=%h, required no rvalid", $time, cpu_rdata);
      end else begin
        mon_rd = exp_cpu_rd.pop_front();
        if (cpu_rdata !== mon_rd) begin
          errors++;
          $display("FAIL cpu_rdata t=%0t: got %h, required %h", $time, cpu_rdata, mon_rd);
        end
      end
    end
    if (dbg_rvalid) begin
      checks++;
      if (exp_dbg_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dbg_rvalid t=%0t: got rdata=%h, required no rvalid", $time, dbg_rdata);
      end else begin
        mon_rd = exp_dbg_rd.pop_front();
        if (dbg_rdata !== mon_rd) begin
          errors++;
          $display("FAIL dbg_rdata t=%0t: got %h, required %h", $time, dbg_rdata, mon_rd);
        end
      end
    end
  end

  task automatic push_g(input logic d, input logic we, input logic [7:0] a, input logic [7:0] wd);
    gnt_t g;
    g = {d, we, a, wd};
    exp_gnt.push_back(g);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [37:0] outs;
    outs = {cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
            mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %h, required 0", name, outs);
    end
  endtask

  task automatic set_cpu(input logic we, input logic [7:0] a, input logic [7:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic we, input logic [7:0] a, input logic [7:0] wd);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
  endtask

  initial begin
    logic d;
    for (int unsigned i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    tb_mem[8'h07] = 8'h2A;
    tb_mem[8'h20] = 8'h3C;
    mem_rdata = 8'h00;
    idle_reqs();
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset held 2 cycles with both requesters active: everything must stay 0.
    reset = 1'b0;
    set_cpu(1'b0, 8'h07, 8'h00);
    set_dbg(1'b1, 8'h10, 8'h55);
    @(negedge clk); check_zero("reset_c0");
    @(negedge clk); check_zero("reset_c1");
    @(posedge clk); #1;
    idle_reqs();
    reset = 1'b1;

    // cpu load of addr 7
    set_cpu(1'b0, 8'h07, 8'h00);
    push_g(1'b0, 1'b0, 8'h07, 8'h00); exp_cpu_rd.push_back(8'h2A);
    cyc(1); idle_reqs(); cyc(2);

    // dbg store then cpu reads it back
    set_dbg(1'b1, 8'h10, 8'h55);
    push_g(1'b1, 1'b1, 8'h10, 8'h55);
    cyc(1); idle_reqs();
    set_cpu(1'b0, 8'h10, 8'h00);
    push_g(1'b0, 1'b0, 8'h10, 8'h00); exp_cpu_rd.push_back(8'h55);
    cyc(1); idle_reqs(); cyc(2);

    // Both requesters held 10 cycles from IDLE
    set_cpu(1'b0, 8'h20, 8'h00);
    set_dbg(1'b1, 8'h30, 8'h99);
    for (int i = 0; i < 10; i++) begin
`ifdef REDUX_ARB_RR_EN
      d = (i % 2) == 1;
`else
      d = (i % 5) == 4;
`endif
      if (d) push_g(1'b1, 1'b1, 8'h30, 8'h99);
      else begin
        push_g(1'b0, 1'b0, 8'h20, 8'h00);
        exp_cpu_rd.push_back(8'h3C);
      end
    end
    cyc(10); idle_reqs(); cyc(2);

    // dbg lock: one solo grant, then 8 contested cycles d,d,d,d,c,d,d,d
    dbg_lock = 1'b1;
    set_dbg(1'b1, 8'h41, 8'h77);
    push_g(1'b1, 1'b1, 8'h41, 8'h77);
    cyc(1);
    set_cpu(1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        push_g(1'b0, 1'b0, 8'h20, 8'h00);
        exp_cpu_rd.push_back(8'h3C);
      end else push_g(1'b1, 1'b1, 8'h41, 8'h77);
    end
    cyc(8); idle_reqs(); cyc(2);

    // Reset asserted the cycle after a granted cpu load: the read response is dropped
    set_cpu(1'b0, 8'h07, 8'h00);
    push_g(1'b0, 1'b0, 8'h07, 8'h00);
    cyc(1);
    reset = 1'b0;
    idle_reqs();
    @(negedge clk); check_zero("reset_mid_read");
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1);

    // Counters restart from 0 after reset: contested run from IDLE
    set_cpu(1'b0, 8'h20, 8'h00);
    set_dbg(1'b1, 8'h30, 8'h99);
    for (int i = 0; i < 5; i++) begin
`ifdef REDUX_ARB_RR_EN
      d = (i % 2) == 1;
`else
      d = (i == 4);
`endif
      if (d) push_g(1'b1, 1'b1, 8'h30, 8'h99);
      else begin
        push_g(1'b0, 1'b0, 8'h20, 8'h00);
        exp_cpu_rd.push_back(8'h3C);
      end
    end
    cyc(5); idle_reqs(); cyc(3);

    checks++;
    if (exp_gnt.size() != 0) begin
      errors++;
      $display("FAIL missing_grants: got %0d grants outstanding, required 0", exp_gnt.size());
    end
    checks++;
    if (exp_cpu_rd.size() != 0) begin
      errors++;
      $display("FAIL missing_cpu_rvalid: got %0d reads outstanding, required 0", exp_cpu_rd.size());
    end
    checks++;
    if (exp_dbg_rd.size() != 0) begin
      errors++;
      $display("FAIL missing_dbg_rvalid: got %0d reads outstanding, required 0", exp_dbg_rd.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
